// File: rtl/threshold_rom.sv
// rtl/threshold_rom.sv - adaptive-threshold lookup ROM (window sum -> saturated mean minus offset)
module threshold_rom #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int SHIFT      = 6,
   parameter int OFFSET     = 7,
   parameter int OUTPUT_REG = 0
) (
   input  logic                  clock,
   input  logic                  aclr,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int MAX_WORD = (2 ** DATA_WIDTH) - 1;
   localparam int TW       = ADDR_WIDTH + 2;

   // Threshold for one window sum: mean minus offset, clamped to the word range.
   // Two extra bits keep the subtraction signed without overflow.
   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
      logic signed [TW-1:0] t;
      t = $signed({2'b00, a >> SHIFT}) - $signed(TW'(OFFSET));
      if (t[TW-1])
         return '0;
      else if (t > $signed(TW'(MAX_WORD)))
         return '1;
      else
         return t[DATA_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] rom [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rom_q;

   // Constant table contents; no write port, so this folds into a ROM.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rom[i] = rom_word(ADDR_WIDTH'(i));
      end
   end

   // Address register; cleared asynchronously so q reads ROM[0] = 0 during reset.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr)
         addr_q <= '0;
      else
         addr_q <= address;
   end

   assign rom_q = rom[addr_q];

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] q_r;

         // Optional output stage; also cleared so no stale word survives a reset.
         always_ff @(posedge clock or posedge aclr) begin
            if (aclr)
               q_r <= '0;
            else
               q_r <= rom_q;
         end

         assign q = q_r;
      end else begin : g_comb
         assign q = rom_q;
      end
   endgenerate

endmodule

// File: tb/tb_threshold_rom.sv
// tb/tb_threshold_rom.sv - scoreboard bench for threshold_rom (latency 1 and latency 2 builds)
`timescale 1ns/1ps
module tb_threshold_rom;

   logic        clock;
   logic        aclr;
   logic [15:0] address;
   logic [7:0]  q0;
   logic [7:0]  q1;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 0;

   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   logic [7:0] pend1;

   threshold_rom #(.OUTPUT_REG(0)) dut0 (
      .clock   (clock),
      .aclr    (aclr),
      .address (address),
      .q       (q0)
   );

   threshold_rom #(.OUTPUT_REG(1), .OFFSET(0)) dut1 (
      .clock   (clock),
      .aclr    (aclr),
      .address (address),
      .q       (q1)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   // Reference: window mean minus offset, clamped to 0..255.
   function automatic logic [7:0] model(input int a, input int off);
      int t;
      t = (a / 64) - off;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      return 8'(t);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive on the falling edge and record what each build must show.
   task automatic step(input int a);
      @(negedge clock);
      address = 16'(a);
      exp0.push_back(model(a, 7));
      exp1.push_back(model(a, 0));
   endtask

   // Hold reset for two cycles checking q = 0, then release well clear of a rising edge.
   task automatic hold_and_release();
      repeat (2) begin
         @(negedge clock);
         check("reset_hold_q0", q0, 8'h00);
         check("reset_hold_q1", q1, 8'h00);
      end
      @(posedge clock);
      #3;
      aclr = 0;
      #1;
      check("post_release_q0", q0, 8'h00);
      check("post_release_q1", q1, 8'h00);
      pend1  = 8'h00;
      mon_en = 1;
   endtask

   // Raise reset mid-cycle and confirm q clears without any clock edge.
   task automatic async_reset();
      @(posedge clock);
      #4;
      mon_en = 0;
      exp0.delete();
      exp1.delete();
      aclr = 1;
      #0.5;
      check("async_clear_q0", q0, 8'h00);
      check("async_clear_q1", q1, 8'h00);
      hold_and_release();
   endtask

   // Latency-1 monitor: each sampled address must show on q right after its edge.
   always begin
      @(posedge clock);
      #2;
      if (mon_en && exp0.size() > 0) begin
         check("q_lat1", q0, exp0.pop_front());
      end
   end

   // Latency-2 monitor: q shows the word whose address was sampled one edge earlier.
   always begin
      @(posedge clock);
      #2;
      if (mon_en && exp1.size() > 0) begin
         check("q_lat2", q1, pend1);
         pend1 = exp1.pop_front();
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      aclr    = 1;
      address = 16'd16383;
      pend1   = 8'h00;
      #1;
      check("reset_q0", q0, 8'h00);
      check("reset_q1", q1, 8'h00);
      hold_and_release();

      step(16383);
      step(16383);

      for (int i = 0; i <= 50; i++) step(i);

      step(447); step(448); step(511); step(512); step(575); step(576);
      step(16767); step(16768); step(65535); step(0);
      step(640); step(640);

      step(16383);
      async_reset();
      step(16383);
      step(640);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 1023);
            1: a = $urandom_range(16000, 17200);
            2: a = $urandom_range(65000, 65535);
            default: a = $urandom_range(0, 65535);
         endcase
         step(a);
         if (i == 200) async_reset();
      end

      step(0);
      step(0);
      repeat (3) @(negedge clock);
      check("queue_drained", 8'(exp0.size() + exp1.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
